// File: rtl/traffic_light_controller_n_pkg.sv
// traffic_light_controller_n_pkg: shared light colours, FSM states and default timings
package traffic_light_controller_n_pkg;

    typedef enum logic [1:0] {
        COL_RED    = 2'd0,
        COL_YELLOW = 2'd1,
        COL_GREEN  = 2'd2
    } colors_t;

    typedef enum logic [2:0] {
        IDLE,
        GREEN,
        YELLOW,
        ALLRED,
        PRE_GREEN
    } phase_state_t;

    localparam int DEF_NUM_PHASES = 3;
    localparam int DEF_GREEN_MIN  = 5;
    localparam int DEF_GREEN_MAX  = 10;
    localparam int DEF_YELLOW_CYC = 2;
    localparam int DEF_ALLRED_CYC = 1;

    // Index width that never collapses to zero bits for tiny phase counts
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/traffic_light_controller_n_rr_phase_arbiter.sv
// rr_phase_arbiter: combinational round-robin pick of the first request after last_served
module rr_phase_arbiter
    import traffic_light_controller_n_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int PH_W       = clog2_min1(NUM_PHASES)
) (
    input  logic [NUM_PHASES-1:0] req_i,
    input  logic [PH_W-1:0]       last_i,
    output logic [PH_W-1:0]       grant_o,
    output logic                  grant_valid_o
);

    logic [PH_W-1:0] k;

    // Scan from farthest to nearest so the nearest set request after last_i wins
    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        k             = '0;
        for (int i = NUM_PHASES; i >= 1; i--) begin
            k = PH_W'((int'(last_i) + i) % NUM_PHASES);
            if (req_i[k]) begin
                grant_o       = k;
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_light_controller_n.sv
// traffic_light_controller_n: N-phase round-robin intersection controller with emergency preempt
module traffic_light_controller_n
    import traffic_light_controller_n_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int GREEN_MIN  = DEF_GREEN_MIN,
    parameter int GREEN_MAX  = DEF_GREEN_MAX,
    parameter int YELLOW_CYC = DEF_YELLOW_CYC,
    parameter int ALLRED_CYC = DEF_ALLRED_CYC,
    parameter int PH_W       = clog2_min1(NUM_PHASES),
    parameter int CNT_W      = $clog2(GREEN_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_PHASES-1:0]    sensor_i,
    input  logic                     preempt_req_i,
    input  logic [PH_W-1:0]          preempt_phase_i,
    output colors_t [NUM_PHASES-1:0] lights_o,
    output logic [PH_W-1:0]          active_phase_o,
    output logic                     preempt_active_o
);

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] G_MIN = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] G_MAX = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] Y_CYC = CNT_W'(YELLOW_CYC);
    localparam logic [CNT_W-1:0] A_CYC = CNT_W'(ALLRED_CYC);

    phase_state_t              state_q, state_d;
    logic [PH_W-1:0]           ph_q, ph_d, last_q, last_d, act_q, act_d;
    logic [CNT_W-1:0]          tmr_q, tmr_d;
    logic                      pa_q, pa_d;
    colors_t [NUM_PHASES-1:0]  lights_q, lights_d;
    logic [PH_W-1:0]           gnt;
    logic                      gnt_v, own, others, lit;
    logic [NUM_PHASES-1:0]     own_mask;

    rr_phase_arbiter #(.NUM_PHASES(NUM_PHASES), .PH_W(PH_W)) u_arb (
        .req_i         (sensor_i),
        .last_i        (last_q),
        .grant_o       (gnt),
        .grant_valid_o (gnt_v)
    );

    assign own_mask = NUM_PHASES'(1) << ph_q;
    assign own      = |(sensor_i & own_mask);
    assign others   = |(sensor_i & ~own_mask);

    // Next-state logic; ph_d also carries the preempt target in PRE_GREEN, which may be out of range
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        last_d  = last_q;
        tmr_d   = tmr_q;
        pa_d    = pa_q;
        case (state_q)
            IDLE: begin
                if (preempt_req_i) begin
                    state_d = PRE_GREEN;
                    ph_d    = preempt_phase_i;
                    pa_d    = 1'b1;
                end else if (gnt_v) begin
                    state_d = GREEN;
                    ph_d    = gnt;
                    last_d  = gnt;
                    tmr_d   = ONE;
                end
            end
            GREEN: begin
                if (preempt_req_i && preempt_phase_i == ph_q) begin
                    state_d = PRE_GREEN;
                    pa_d    = 1'b1;
                end else if (preempt_req_i || (tmr_q >= G_MIN && !own) || (tmr_q >= G_MAX && others)) begin
                    state_d = YELLOW;
                    tmr_d   = ONE;
                    pa_d    = preempt_req_i;
                end else if (tmr_q < G_MAX) begin
                    tmr_d = tmr_q + ONE;
                end
            end
            YELLOW: begin
                pa_d    = preempt_req_i;
                state_d = (tmr_q == Y_CYC) ? ALLRED : YELLOW;
                tmr_d   = (tmr_q == Y_CYC) ? ONE : tmr_q + ONE;
            end
            ALLRED: begin
                pa_d  = preempt_req_i;
                tmr_d = tmr_q + ONE;
                if (tmr_q == A_CYC) begin
                    tmr_d   = '0;
                    state_d = IDLE;
                    if (preempt_req_i) begin
                        state_d = PRE_GREEN;
                        ph_d    = preempt_phase_i;
                    end else if (gnt_v) begin
                        state_d = GREEN;
                        ph_d    = gnt;
                        last_d  = gnt;
                        tmr_d   = ONE;
                    end
                end
            end
            PRE_GREEN: begin
                if (!preempt_req_i) begin
                    pa_d  = 1'b0;
                    tmr_d = ONE;
                    if (int'(ph_q) < NUM_PHASES) begin
                        state_d = YELLOW;
                        last_d  = ph_q;
                    end else begin
                        state_d = ALLRED;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        lit   = (state_d inside {GREEN, YELLOW, PRE_GREEN}) && (int'(ph_d) < NUM_PHASES);
        act_d = lit ? ph_d : '0;
        for (int i = 0; i < NUM_PHASES; i++)
            lights_d[i] = (!lit || ph_d != PH_W'(i)) ? COL_RED : (state_d == YELLOW) ? COL_YELLOW : COL_GREEN;
    end

    // State and registered outputs; reset forces all-red with phase 0 next in line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ph_q     <= '0;
            last_q   <= PH_W'(NUM_PHASES - 1);
            tmr_q    <= '0;
            pa_q     <= 1'b0;
            act_q    <= '0;
            lights_q <= {NUM_PHASES{COL_RED}};
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            last_q   <= last_d;
            tmr_q    <= tmr_d;
            pa_q     <= pa_d;
            act_q    <= act_d;
            lights_q <= lights_d;
        end
    end

    assign lights_o         = lights_q;
    assign active_phase_o   = act_q;
    assign preempt_active_o = pa_q;

endmodule

// File: tb/tb_traffic_light_controller_n.sv
// tb_traffic_light_controller_n: directed checks on the 3-phase default plus a randomised 5-phase safety run
module tb_traffic_light_controller_n;
    import traffic_light_controller_n_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2:0]    sensor = '0;
    logic          preq = 1'b0;
    logic [1:0]    pph = '0;
    colors_t [2:0] lights;
    logic [5:0]    lv;
    logic [1:0]    act;
    logic          pa;

    logic [4:0]    s5 = '0;
    logic          p5 = 1'b0;
    logic [2:0]    pp5 = '0;
    colors_t [4:0] l5;
    logic [2:0]    a5;
    logic          pa5;

    int n_assert = 0;
    int n_fail = 0;

    assign lv = lights;

    traffic_light_controller_n dut (
        .clk              (clk),
        .reset            (reset),
        .sensor_i         (sensor),
        .preempt_req_i    (preq),
        .preempt_phase_i  (pph),
        .lights_o         (lights),
        .active_phase_o   (act),
        .preempt_active_o (pa)
    );

    traffic_light_controller_n #(.NUM_PHASES(5)) dut5 (
        .clk              (clk),
        .reset            (reset),
        .sensor_i         (s5),
        .preempt_req_i    (p5),
        .preempt_phase_i  (pp5),
        .lights_o         (l5),
        .active_phase_o   (a5),
        .preempt_active_o (pa5)
    );

    function automatic logic [5:0] ex(input int ph, input colors_t c);
        logic [5:0] v;
        v = '0;
        if (c != COL_RED) v[ph*2 +: 2] = c;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input int ph, input colors_t c, input logic pex, input int n);
        repeat (n) begin
            @(negedge clk);
            chk({tag, " lights"}, 32'(lv), 32'(ex(ph, c)));
            chk({tag, " phase"}, 32'(act), (c == COL_RED) ? 32'd0 : 32'(ph));
            chk({tag, " preempt_active"}, 32'(pa), 32'(pex));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        sensor = '0;
        preq   = 1'b0;
        pph    = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int   ycnt, gcnt, nonred;
    logic gpre, yel, grn;

    initial begin
        reset = 1'b1;
        #1;
        chk("reset lights", 32'(lv), 32'd0);
        chk("reset phase", 32'(act), 32'd0);
        chk("reset preempt_active", 32'(pa), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        sensor = 3'b010;
        run("t1 green", 1, COL_GREEN, 1'b0, 2);
        sensor = 3'b000;
        run("t1 green", 1, COL_GREEN, 1'b0, 3);
        run("t1 yellow", 1, COL_YELLOW, 1'b0, 2);
        run("t1 red", 0, COL_RED, 1'b0, 3);

        do_reset();
        sensor = 3'b111;
        for (int p = 0; p < 3; p++) begin
            run("t2 green", p, COL_GREEN, 1'b0, 10);
            run("t2 yellow", p, COL_YELLOW, 1'b0, 2);
            run("t2 red", 0, COL_RED, 1'b0, 1);
        end
        run("t2 wrap green", 0, COL_GREEN, 1'b0, 2);

        do_reset();
        sensor = 3'b100;
        run("t3 green", 2, COL_GREEN, 1'b0, 20);
        sensor = 3'b101;
        run("t3 yellow", 2, COL_YELLOW, 1'b0, 2);
        run("t3 red", 0, COL_RED, 1'b0, 1);
        run("t3 next green", 0, COL_GREEN, 1'b0, 3);

        do_reset();
        sensor = 3'b001;
        run("t4 green", 0, COL_GREEN, 1'b0, 2);
        preq = 1'b1;
        pph  = 2'd2;
        run("t4 forced yellow", 0, COL_YELLOW, 1'b1, 2);
        run("t4 clear red", 0, COL_RED, 1'b1, 1);
        run("t4 preempt green", 2, COL_GREEN, 1'b1, 15);
        preq = 1'b0;
        run("t4 release yellow", 2, COL_YELLOW, 1'b0, 2);
        run("t4 release red", 0, COL_RED, 1'b0, 1);
        run("t4 resume green", 0, COL_GREEN, 1'b0, 3);

        do_reset();
        sensor = 3'b001;
        run("pg same green", 0, COL_GREEN, 1'b0, 1);
        preq   = 1'b1;
        pph    = 2'd0;
        sensor = 3'b111;
        run("pg same held", 0, COL_GREEN, 1'b1, 12);
        preq = 1'b0;
        run("pg same yellow", 0, COL_YELLOW, 1'b0, 2);
        run("pg same red", 0, COL_RED, 1'b0, 1);
        run("pg same next", 1, COL_GREEN, 1'b0, 2);

        do_reset();
        preq   = 1'b1;
        pph    = 2'd3;
        sensor = 3'b111;
        run("pg invalid hold", 0, COL_RED, 1'b1, 4);
        preq = 1'b0;
        run("pg invalid red", 0, COL_RED, 1'b0, 1);
        run("pg invalid resume", 0, COL_GREEN, 1'b0, 2);

        do_reset();
        sensor = 3'b111;
        run("t5 green", 0, COL_GREEN, 1'b0, 10);
        run("t5 yellow", 0, COL_YELLOW, 1'b0, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5 async lights", 32'(lv), 32'd0);
        chk("t5 async phase", 32'(act), 32'd0);
        chk("t5 async preempt_active", 32'(pa), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run("t5 restart green", 0, COL_GREEN, 1'b0, 2);

        ycnt = 0;
        gcnt = 0;
        gpre = 1'b0;
        repeat (5000) begin
            @(negedge clk);
            nonred = 0;
            yel    = 1'b0;
            grn    = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (l5[i] != COL_RED) nonred++;
                if (l5[i] == COL_YELLOW) yel = 1'b1;
                if (l5[i] == COL_GREEN) grn = 1'b1;
            end
            chk("rand exclusive", 32'(nonred <= 1), 32'd1);
            if (grn) begin
                gcnt++;
                gpre = gpre | p5;
            end else if (gcnt > 0) begin
                if (gcnt < DEF_GREEN_MIN) chk("rand short green preempted", 32'(gpre | p5), 32'd1);
                gcnt = 0;
                gpre = 1'b0;
            end
            if (yel) ycnt++;
            else if (ycnt > 0) begin
                chk("rand yellow length", 32'(ycnt), 32'(DEF_YELLOW_CYC));
                ycnt = 0;
            end
            s5 = 5'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                p5  = ~p5;
                pp5 = 3'($urandom_range(0, 7));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
